// File: rtl/btn_pkg.sv
// Shared types and limits for the push-button conditioning path.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    PRESSED   = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam int DEBOUNCE_MIN = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (clr) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Synchronise, debounce and strobe a raw push-button; hold a load request
// until the downstream slow-clock tick so the counter never misses a press.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_in,
  input  logic tick,
  output logic level,
  output logic press,
  output logic load_req,
  output logic overrun
);

  // Below-minimum settings are clamped rather than producing a zero-length window.
  localparam int DB_EFF = (DEBOUNCE_CYCLES < DEBOUNCE_MIN) ? DEBOUNCE_MIN : DEBOUNCE_CYCLES;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_EFF - 1);

  logic             btn_s;
  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             press_d;
  logic             load_req_d;
  logic             overrun_d;

  sync_2ff u_sync (
    .clk (clk),
    .clr (clr),
    .d   (btn_in),
    .q   (btn_s)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    press_d = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (btn_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // overrun is aligned with press, so it looks at load_req as it will be in the press cycle.
  always_comb begin
    load_req_d = load_req;
    if (press) begin
      load_req_d = 1'b1;
    end else if (tick && load_req) begin
      load_req_d = 1'b0;
    end
    overrun_d = press_d && load_req && !tick;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      cnt      <= '0;
      level    <= 1'b0;
      press    <= 1'b0;
      load_req <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      level    <= (state_d == PRESSED) || (state_d == WAIT_LOW);
      press    <= press_d;
      load_req <= load_req_d;
      overrun  <= overrun_d;
    end
  end

endmodule
